ifid_fifo: RTL and testbench

Parametrised IF/ID decoupling stage for the 5-stage MIPS pipeline: a DEPTH-entry instruction queue between fetch and decode that replaces the single IF/ID latch. Fetch pushes {instruction, PC+4} under a valid/ready handshake. Decode sees the head entry already split into op/rs/rt/rd/imm/func fields plus a computed jump target. Hazard stall holds the head, and branch/jump flush empties the whole queue in one cycle.

---
 rtl/ifid_fifo_pkg.sv | 64 ++++++
 rtl/ifid_fifo_if.sv | 40 ++++
 rtl/ifid_fifo_mem.sv | 37 +++
 rtl/ifid_fifo.sv | 106 ++++++++++
 tb/tb_ifid_fifo.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/ifid_fifo_pkg.sv
// MIPS instruction field layout and helpers shared by the IF/ID queue, decode and ID/EX.
package ifid_fifo_pkg;

    localparam int INSTR_W = 32;
    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int IMM_W   = 16;
    localparam int FUNC_W  = 6;
    localparam int JIDX_W  = 26;

    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int RS_MSB   = 25;
    localparam int RS_LSB   = 21;
    localparam int RT_MSB   = 20;
    localparam int RT_LSB   = 16;
    localparam int RD_MSB   = 15;
    localparam int RD_LSB   = 11;
    localparam int IMM_MSB  = 15;
    localparam int IMM_LSB  = 0;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;
    localparam int JIDX_MSB = 25;
    localparam int JIDX_LSB = 0;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [OP_W-1:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [IMM_W-1:0]  imm;
        logic [FUNC_W-1:0] func;
    } ifid_fields_t;

    function automatic ifid_fields_t split_instr(input logic [INSTR_W-1:0] instr);
        ifid_fields_t f;
        f.op   = instr[OP_MSB:OP_LSB];
        f.rs   = instr[RS_MSB:RS_LSB];
        f.rt   = instr[RT_MSB:RT_LSB];
        f.rd   = instr[RD_MSB:RD_LSB];
        f.imm  = instr[IMM_MSB:IMM_LSB];
        f.func = instr[FUNC_MSB:FUNC_LSB];
        return f;
    endfunction

    function automatic logic [INSTR_W-1:0] sign_extend16(input logic [IMM_W-1:0] v);
        return {{(INSTR_W-IMM_W){v[IMM_W-1]}}, v};
    endfunction

endpackage

// File: rtl/ifid_fifo_if.sv
// Fetch-side push handshake, hazard controls and decode-side head view of the IF/ID queue.
interface ifid_fifo_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_next_pc;
    logic            in_ready;
    logic            stall;
    logic            flush;

    logic            out_valid;
    logic [5:0]      op;
    logic [4:0]      ifid_rs;
    logic [4:0]      ifid_rt;
    logic [4:0]      ifid_rd;
    logic [15:0]     imm;
    logic [31:0]     imm_sext;
    logic [5:0]      func;
    logic [PC_W-1:0] out_next_pc;
    logic [PC_W-1:0] jump_addr;
    logic [CW-1:0]   count;

    // Pipeline side: fetch pushes, hazard unit stalls/flushes, decode consumes.
    modport master (
        output in_valid, in_instr, in_next_pc, stall, flush,
        input  in_ready, out_valid, op, ifid_rs, ifid_rt, ifid_rd,
               imm, imm_sext, func, out_next_pc, jump_addr, count
    );

    modport slave (
        input  in_valid, in_instr, in_next_pc, stall, flush,
        output in_ready, out_valid, op, ifid_rs, ifid_rt, ifid_rd,
               imm, imm_sext, func, out_next_pc, jump_addr, count
    );

endinterface

// File: rtl/ifid_fifo_mem.sv
// DEPTH-entry register array: one synchronous write port, one asynchronous read port, async clear.
module ifid_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] entry_q [DEPTH];

    // Per-entry registers so each slot has its own enable and clear.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (wr_en && (wr_addr == AW'(gi))) begin
                    entry_reg <= wr_data;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    assign rd_data = entry_q[rd_addr];

endmodule

// File: rtl/ifid_fifo.sv
// IF/ID instruction queue: pointer/count control plus combinational split of the head entry.
module ifid_fifo
    import ifid_fifo_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int PC_W        = 32,
    parameter bit ZERO_BUBBLE = 1'b1
) (
    input logic        clk,
    input logic        rst_n,
    ifid_fifo_if.slave bus
);
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRY_W = INSTR_W + PC_W;

    logic [AW-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]      count_reg, count_next;
    logic               full, empty, push, pop;
    logic [ENTRY_W-1:0] head_entry;
    logic [INSTR_W-1:0] head_instr;
    logic [PC_W-1:0]    head_pc;
    ifid_fields_t       head_fields;

    // Handshake status comes only from the registered count.
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    assign push = bus.in_valid & ~full & ~bus.flush;
    assign pop  = ~empty & ~bus.stall & ~bus.flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (bus.flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_next = count_reg + 1'b1;
            end else if (pop && !push) begin
                count_next = count_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    ifid_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data ({bus.in_instr, bus.in_next_pc}),
        .rd_addr (rd_ptr_reg),
        .rd_data (head_entry)
    );

    // An empty queue presents a NOP bubble to decode when ZERO_BUBBLE is set.
    always_comb begin
        head_instr = head_entry[ENTRY_W-1:PC_W];
        head_pc    = head_entry[PC_W-1:0];
        if (ZERO_BUBBLE && empty) begin
            head_instr = NOP_INSTR;
            head_pc    = '0;
        end
    end

    assign head_fields = split_instr(head_instr);

    assign bus.in_ready    = ~full;
    assign bus.out_valid   = ~empty;
    assign bus.count       = count_reg;
    assign bus.op          = head_fields.op;
    assign bus.ifid_rs     = head_fields.rs;
    assign bus.ifid_rt     = head_fields.rt;
    assign bus.ifid_rd     = head_fields.rd;
    assign bus.imm         = head_fields.imm;
    assign bus.imm_sext    = sign_extend16(head_fields.imm);
    assign bus.func        = head_fields.func;
    assign bus.out_next_pc = head_pc;
    assign bus.jump_addr   = {head_pc[PC_W-1:28], head_instr[JIDX_MSB:JIDX_LSB], 2'b00};

endmodule

// File: tb/tb_ifid_fifo.sv
// Directed bench for ifid_fifo: a vector table plus hand sequences for stall, flush and async reset.
module tb_ifid_fifo;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    localparam logic [31:0] I_A = 32'h0800_0010, P_A = 32'h4000_0004; // j
    localparam logic [31:0] I_B = 32'h2008_FFFF, P_B = 32'h0000_0008; // addi $t0,$0,-1
    localparam logic [31:0] I_C = 32'h012A_4020, P_C = 32'h0000_000C; // add $t0,$t1,$t2
    localparam logic [31:0] I_D = 32'h8D09_0004, P_D = 32'h0000_0010; // lw
    localparam logic [31:0] I_E = 32'h3C01_1234, P_E = 32'h0000_0014; // lui

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifid_fifo_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus_if ();

    ifid_fifo #(
        .DEPTH       (DEPTH),
        .PC_W        (PC_W),
        .ZERO_BUBBLE (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic        in_valid;
        logic [31:0] instr;
        logic [31:0] next_pc;
        logic        stall;
        logic        flush;
        int          exp_count;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t tbl [18];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic st, input logic fl);
        bus_if.in_valid   = v;
        bus_if.in_instr   = ins;
        bus_if.in_next_pc = pc;
        bus_if.stall      = st;
        bus_if.flush      = fl;
    endtask

    // Expected decode view derived from the expected head word by plain bit slicing.
    task automatic check_head(input string tag, input int exp_count,
                              input logic [31:0] hi, input logic [31:0] hp);
        logic [31:0] sext;
        logic [31:0] jaddr;
        sext  = {{16{hi[15]}}, hi[15:0]};
        jaddr = {hp[31:28], hi[25:0], 2'b00};
        check($sformatf("%s.count", tag),     64'(bus_if.count), 64'(exp_count));
        check($sformatf("%s.out_valid", tag), 64'(bus_if.out_valid), 64'(exp_count != 0));
        check($sformatf("%s.in_ready", tag),  64'(bus_if.in_ready), 64'(exp_count != DEPTH));
        check($sformatf("%s.op", tag),        64'(bus_if.op), 64'(hi[31:26]));
        check($sformatf("%s.rs", tag),        64'(bus_if.ifid_rs), 64'(hi[25:21]));
        check($sformatf("%s.rt", tag),        64'(bus_if.ifid_rt), 64'(hi[20:16]));
        check($sformatf("%s.rd", tag),        64'(bus_if.ifid_rd), 64'(hi[15:11]));
        check($sformatf("%s.imm", tag),       64'(bus_if.imm), 64'(hi[15:0]));
        check($sformatf("%s.imm_sext", tag),  64'(bus_if.imm_sext), 64'(sext));
        check($sformatf("%s.func", tag),      64'(bus_if.func), 64'(hi[5:0]));
        check($sformatf("%s.next_pc", tag),   64'(bus_if.out_next_pc), 64'(hp));
        check($sformatf("%s.jump_addr", tag), 64'(bus_if.jump_addr), 64'(jaddr));
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        //            v     instr  pc    stall flush  count head  head_pc
        tbl[0]  = '{1'b1, I_A, P_A, 1'b0, 1'b0, 1, I_A, P_A};
        tbl[1]  = '{1'b1, I_B, P_B, 1'b1, 1'b0, 2, I_A, P_A};
        tbl[2]  = '{1'b1, I_C, P_C, 1'b1, 1'b0, 3, I_A, P_A};
        tbl[3]  = '{1'b1, I_D, P_D, 1'b1, 1'b0, 4, I_A, P_A};
        tbl[4]  = '{1'b1, I_E, P_E, 1'b1, 1'b0, 4, I_A, P_A};   // full: push refused
        tbl[5]  = '{1'b1, I_E, P_E, 1'b0, 1'b0, 3, I_B, P_B};   // full: pop only
        tbl[6]  = '{1'b1, I_E, P_E, 1'b1, 1'b0, 4, I_B, P_B};
        tbl[7]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3, I_C, P_C};
        tbl[8]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2, I_D, P_D};
        tbl[9]  = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1, I_E, P_E};
        tbl[10] = '{1'b1, I_A, P_A, 1'b0, 1'b0, 1, I_A, P_A};   // simultaneous push/pop
        tbl[11] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 0, 32'h0, 32'h0};
        tbl[12] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 0, 32'h0, 32'h0};
        tbl[13] = '{1'b1, I_B, P_B, 1'b0, 1'b0, 1, I_B, P_B};   // empty: no bypass
        tbl[14] = '{1'b1, I_C, P_C, 1'b1, 1'b0, 2, I_B, P_B};
        tbl[15] = '{1'b1, I_D, P_D, 1'b1, 1'b0, 3, I_B, P_B};
        tbl[16] = '{1'b1, I_A, P_A, 1'b1, 1'b1, 0, 32'h0, 32'h0}; // flush beats stall and push
        tbl[17] = '{1'b1, I_D, P_D, 1'b0, 1'b0, 1, I_D, P_D};

        do_reset();
        check_head("reset", 0, 32'h0, 32'h0);

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].in_valid, tbl[i].instr, tbl[i].next_pc, tbl[i].stall, tbl[i].flush);
            step();
            $display("vec %0d: v=%0b instr=%h st=%0b fl=%0b -> count=%0d op=%h",
                     i, tbl[i].in_valid, tbl[i].instr, tbl[i].stall, tbl[i].flush,
                     bus_if.count, bus_if.op);
            check_head($sformatf("vec%0d", i), tbl[i].exp_count, tbl[i].exp_instr, tbl[i].exp_pc);
        end

        // Jump instruction right after reset.
        do_reset();
        drive(1'b1, I_A, P_A, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        $display("jump push: op=%h jump_addr=%h count=%0d", bus_if.op, bus_if.jump_addr, bus_if.count);
        check("jmp.out_valid", 64'(bus_if.out_valid), 64'h1);
        check("jmp.op", 64'(bus_if.op), 64'h02);
        check("jmp.jump_addr", 64'(bus_if.jump_addr), 64'h4000_0040);
        check("jmp.count", 64'(bus_if.count), 64'h1);

        // Replace head with addi, then hold it under stall for three cycles.
        drive(1'b1, I_B, P_B, 1'b0, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            $display("stall cycle %0d: op=%h imm_sext=%h count=%0d", c, bus_if.op, bus_if.imm_sext, bus_if.count);
            check($sformatf("stall%0d.op", c), 64'(bus_if.op), 64'h08);
            check($sformatf("stall%0d.rt", c), 64'(bus_if.ifid_rt), 64'h08);
            check($sformatf("stall%0d.imm_sext", c), 64'(bus_if.imm_sext), 64'hFFFF_FFFF);
            check($sformatf("stall%0d.count", c), 64'(bus_if.count), 64'h1);
        end

        // Build count=2, then assert reset mid-cycle with a push pending.
        drive(1'b1, I_C, P_C, 1'b1, 1'b0);
        step();
        check("prerst.count", 64'(bus_if.count), 64'h2);
        drive(1'b1, I_D, P_D, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: count=%0d out_valid=%0b op=%h", bus_if.count, bus_if.out_valid, bus_if.op);
        check("arst.count", 64'(bus_if.count), 64'h0);
        check("arst.out_valid", 64'(bus_if.out_valid), 64'h0);
        check("arst.op", 64'(bus_if.op), 64'h0);
        check("arst.imm_sext", 64'(bus_if.imm_sext), 64'h0);
        check("arst.next_pc", 64'(bus_if.out_next_pc), 64'h0);
        step();
        check("arst_hold.count", 64'(bus_if.count), 64'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        $display("after release: in_ready=%0b count=%0d", bus_if.in_ready, bus_if.count);
        check("rel.in_ready", 64'(bus_if.in_ready), 64'h1);
        check("rel.count", 64'(bus_if.count), 64'h0);
        check("rel.out_valid", 64'(bus_if.out_valid), 64'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
